lcd_hd44780_ctrl: RTL and testbench
===================================

// Module: lcd_hd44780_ctrl
// PURPOSE
//   Parametrised HD44780-compatible character-LCD driver, successor to the fixed 8-bit LCD controller.
//   Runs the power-up and initialisation sequence itself, in 8-bit or 4-bit bus mode and for 1 or 2 lines.
//   After init it accepts command/character bytes over a valid/ready handshake.
//   It generates the E strobe and per-instruction wait times from CLOCK_50 cycle counts.
//   It sits between application logic (text/cursor writer) and the GPIO_0 LCD pins in the top module.
// PARAMETERS
//   BUS_WIDTH      8          LCD data bus width; 8 or 4 (any other value = elaboration error)
//   NUM_LINES      2          1 or 2; selects function-set N bit
//   POWERUP_CYC    2_000_000  wait after reset before first access (40 ms @ 50 MHz)
//   WAKE_WAIT_CYC  250_000    wait after 1st wake-up 0x30 (5 ms)
//   SETUP_CYC      4          RS/data stable before E rises (80 ns)
//   E_HIGH_CYC     25         E high width (500 ns)
//   HOLD_CYC       4          RS/data held after E falls (80 ns)
//   CMD_WAIT_CYC   2_500      post-instruction wait, normal commands/data (50 us)
//   CLEAR_WAIT_CYC 100_000    post-instruction wait for 0x01 clear and 0x02/0x03 home (2 ms)
// PORTS
//   CLOCK_50   in   1  system clock
//   rst        in   1  synchronous, active-high reset
//   cmd_valid  in   1  cmd_rs/cmd_data valid
//   cmd_ready  out  1  controller can accept a byte this cycle
//   cmd_rs     in   1  0 = instruction, 1 = character data
//   cmd_data   in   8  byte to send
//   init_done  out  1  init sequence complete (sticky until rst)
//   lcd_rs     out  1  LCD register select
//   lcd_rw     out  1  LCD read/write (always 0, write-only)
//   lcd_e      out  1  LCD enable strobe (LCD latches on falling edge)
//   lcd_data   out  8  LCD DB7..DB0; in 4-bit mode nibble on [7:4], [3:0] driven 0
// BEHAVIOUR
//   Reset (sync, sampled on CLOCK_50 rising edge): lcd_rs=0, lcd_rw=0, lcd_e=0, lcd_data=0, cmd_ready=0, init_done=0.
//     FSM -> POWERUP, all counters cleared. rst asserted mid-transfer aborts immediately; E falls on the next edge.
//   Main FSM: POWERUP -> INIT_SEQ -> IDLE <-> XFER -> WAIT -> IDLE.
//   POWERUP: count POWERUP_CYC cycles, then INIT_SEQ.
//   INIT_SEQ: ROM-driven list, each entry sent as one strobe (wake-ups are single 8-bit/upper-nibble writes):
//     wake 0x30, wait WAKE_WAIT_CYC; wake 0x30, wait CMD_WAIT_CYC; wake 0x30, wait CMD_WAIT_CYC.
//     4-bit only: nibble 0x2 (single strobe), wait CMD_WAIT_CYC.
//     Function set {3'b001, DL=(BUS_WIDTH==8), N=(NUM_LINES==2), 3'b000}: 0x38 (8b/2L), 0x28 (4b/2L), 0x30 (8b/1L).
//     Then 0x0C display on; 0x01 clear (CLEAR_WAIT_CYC); 0x06 entry increment.
//     On leaving the last wait: init_done=1, FSM -> IDLE.
//   IDLE: cmd_ready=1. Transfer accepted when cmd_valid && cmd_ready at a rising edge; byte and rs are latched.
//     cmd_ready=0 from the next cycle until the return to IDLE. cmd_valid is ignored while cmd_ready=0.
//   Strobe timing (one nibble or byte): lcd_rs/lcd_data driven, E=0 for SETUP_CYC; E=1 for E_HIGH_CYC;
//     E=0 for HOLD_CYC with data held. Data/RS only change while E=0.
//   XFER, 8-bit: one strobe. 4-bit: high nibble strobe then low nibble strobe, back-to-back (no extra gap).
//   WAIT: if rs=0 and (data==0x01 or data[7:1]==7'b0000001), CLEAR_WAIT_CYC; else CMD_WAIT_CYC. Then IDLE.
//     lcd_data/lcd_rs retain their last value; E stays 0.
//   Accept-to-next-ready: 8-bit = SETUP+E_HIGH+HOLD+WAIT+1 cycles; 4-bit adds SETUP+E_HIGH+HOLD.
//   Counter: a single down-counter sized $clog2 of the largest cycle parameter +1. A parameter value of 0 is treated as 1.
//   lcd_rw is constant 0; no busy-flag reads.
// TESTING (bench uses POWERUP=50, WAKE=20, SETUP=2, E_HIGH=3, HOLD=2, CMD_WAIT=10, CLEAR_WAIT=40)
//   8-bit/2L reset release -> 7 E falling edges latching 0x30,0x30,0x30,0x38,0x0C,0x01,0x06; init_done rises after last wait.
//   BUS_WIDTH=4 -> edges latch nibbles 3,3,3,2 then 2,8,0,C,0,1,0,6; lcd_data[3:0] always 0.
//   After init, send rs=1 data 0x41 -> lcd_rs=1, lcd_data=0x41 stable across E pulse; cmd_ready returns after 2+3+2+10+1 = 18 cycles.
//   Send rs=0 0x01 then rs=0 0x80 -> first WAIT is 40 cycles, second is 10; cmd_valid held high during the busy period accepts no extra byte.
//   rst asserted during E high of a data write -> next edge: lcd_e=0, lcd_data=0, cmd_ready=0, init_done=0; POWERUP restarts.
//   Back-to-back cmd_valid held high for 3 bytes -> exactly 3 transfers, in order, each after cmd_ready=1.

Source files
------------

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780-compatible character LCD driver: runs power-up/init in 8- or 4-bit mode,
// then forwards command/character bytes from a valid/ready port with E strobe timing.
module lcd_hd44780_ctrl #(
  parameter int BUS_WIDTH      = 8,
  parameter int NUM_LINES      = 2,
  parameter int POWERUP_CYC    = 2_000_000,
  parameter int WAKE_WAIT_CYC  = 250_000,
  parameter int SETUP_CYC      = 4,
  parameter int E_HIGH_CYC     = 25,
  parameter int HOLD_CYC       = 4,
  parameter int CMD_WAIT_CYC   = 2_500,
  parameter int CLEAR_WAIT_CYC = 100_000
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  typedef enum logic [2:0] {
    S_POWERUP   = 3'd0,
    S_INIT      = 3'd1,
    S_INIT_WAIT = 3'd2,
    S_IDLE      = 3'd3,
    S_XFER      = 3'd4,
    S_WAIT      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PH_SETUP = 2'd0,
    PH_HIGH  = 2'd1,
    PH_HOLD  = 2'd2
  } phase_e;

  typedef enum logic [1:0] {
    W_CMD  = 2'd0,
    W_CLR  = 2'd1,
    W_WAKE = 2'd2
  } wait_e;

  function automatic int at_least_one(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int PU_CYC  = at_least_one(POWERUP_CYC);
  localparam int WK_CYC  = at_least_one(WAKE_WAIT_CYC);
  localparam int ST_CYC  = at_least_one(SETUP_CYC);
  localparam int EH_CYC  = at_least_one(E_HIGH_CYC);
  localparam int HD_CYC  = at_least_one(HOLD_CYC);
  localparam int CMD_CYC = at_least_one(CMD_WAIT_CYC);
  localparam int CLR_CYC = at_least_one(CLEAR_WAIT_CYC);
  localparam int MAX_CYC = max_of(max_of(max_of(PU_CYC, WK_CYC), max_of(ST_CYC, EH_CYC)),
                                  max_of(max_of(HD_CYC, CMD_CYC), CLR_CYC));
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] LD_PU  = CNT_W'(PU_CYC - 1);
  localparam logic [CNT_W-1:0] LD_WK  = CNT_W'(WK_CYC - 1);
  localparam logic [CNT_W-1:0] LD_ST  = CNT_W'(ST_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EH  = CNT_W'(EH_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HD  = CNT_W'(HD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CMD = CNT_W'(CMD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CLR = CNT_W'(CLR_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic       IS_4BIT  = (BUS_WIDTH == 4) ? 1'b1 : 1'b0;
  localparam logic       DL_BIT   = (BUS_WIDTH == 8) ? 1'b1 : 1'b0;
  localparam logic       N_BIT    = (NUM_LINES == 2) ? 1'b1 : 1'b0;
  localparam logic [7:0] FUNC_SET = {3'b001, DL_BIT, N_BIT, 3'b000};
  localparam logic [2:0] LAST_IDX = IS_4BIT ? 3'd7 : 3'd6;

  generate
    if (BUS_WIDTH != 8 && BUS_WIDTH != 4) begin : g_bad_bus_width
      $error("lcd_hd44780_ctrl: BUS_WIDTH must be 8 or 4");
    end
    if (NUM_LINES != 1 && NUM_LINES != 2) begin : g_bad_num_lines
      $error("lcd_hd44780_ctrl: NUM_LINES must be 1 or 2");
    end
  endgenerate

  function automatic logic [CNT_W-1:0] wait_load(input wait_e w);
    case (w)
      W_CLR:   return LD_CLR;
      W_WAKE:  return LD_WK;
      default: return LD_CMD;
    endcase
  endfunction

  // Init ROM entry = {byte, single_strobe, wait_sel}; slot 3 (nibble 0x2) exists only on a 4-bit bus.
  function automatic logic [10:0] rom_entry(input logic [2:0] idx);
    logic [2:0] slot;
    slot = (!IS_4BIT && idx >= 3'd3) ? idx + 3'd1 : idx;
    case (slot)
      3'd0:    return {8'h30, 1'b1, W_WAKE};
      3'd1:    return {8'h30, 1'b1, W_CMD};
      3'd2:    return {8'h30, 1'b1, W_CMD};
      3'd3:    return {8'h20, 1'b1, W_CMD};
      3'd4:    return {FUNC_SET, 1'b0, W_CMD};
      3'd5:    return {8'h0C, 1'b0, W_CMD};
      3'd6:    return {8'h01, 1'b0, W_CLR};
      3'd7:    return {8'h06, 1'b0, W_CMD};
      default: return {8'h06, 1'b0, W_CMD};
    endcase
  endfunction

  function automatic logic [7:0] pin_byte(input logic [7:0] b, input logic hi);
    if (!IS_4BIT) begin
      return b;
    end else if (hi) begin
      return {b[7:4], 4'h0};
    end else begin
      return {b[3:0], 4'h0};
    end
  endfunction

  state_e           state_r, state_nx;
  phase_e           phase_r, phase_nx;
  wait_e            wsel_r, wsel_nx;
  logic [CNT_W-1:0] cnt_r, cnt_nx;
  logic [2:0]       idx_r, idx_nx;
  logic             nib_hi_r, nib_hi_nx;
  logic [7:0]       byte_r, byte_nx;
  logic             rs_r, rs_nx;
  logic             single_r, single_nx;
  logic             init_done_r, init_done_nx;
  logic             cmd_ready_r, cmd_ready_nx;
  logic             lcd_rs_r, lcd_rs_nx;
  logic             lcd_e_r, lcd_e_nx;
  logic [7:0]       lcd_data_r, lcd_data_nx;
  logic             accept_s, cnt_last_s, strobe_nx_s, slow_cmd_s;
  logic [2:0]       rom_sel_s;
  logic [10:0]      rom_s;

  assign accept_s   = (state_r == S_IDLE) && cmd_valid && cmd_ready_r;
  assign cnt_last_s = (cnt_r == CNT_ZERO);
  assign slow_cmd_s = !cmd_rs && ((cmd_data == 8'h01) || (cmd_data[7:1] == 7'b0000001));
  assign rom_sel_s  = (state_r == S_POWERUP) ? 3'd0 : idx_r + 3'd1;
  assign rom_s      = rom_entry(rom_sel_s);

  // Next-state, sequencing counter and next values of the registered pin outputs.
  always_comb begin
    state_nx     = state_r;
    phase_nx     = phase_r;
    wsel_nx      = wsel_r;
    cnt_nx       = cnt_r;
    idx_nx       = idx_r;
    nib_hi_nx    = nib_hi_r;
    byte_nx      = byte_r;
    rs_nx        = rs_r;
    single_nx    = single_r;
    init_done_nx = init_done_r;

    case (state_r)
      S_POWERUP, S_INIT_WAIT: begin
        if (!cnt_last_s) begin
          cnt_nx = cnt_r - CNT_ONE;
        end else if (state_r == S_INIT_WAIT && idx_r == LAST_IDX) begin
          state_nx     = S_IDLE;
          init_done_nx = 1'b1;
        end else begin
          state_nx  = S_INIT;
          phase_nx  = PH_SETUP;
          cnt_nx    = LD_ST;
          nib_hi_nx = 1'b1;
          idx_nx    = rom_sel_s;
          byte_nx   = rom_s[10:3];
          single_nx = rom_s[2];
          wsel_nx   = wait_e'(rom_s[1:0]);
          rs_nx     = 1'b0;
        end
      end
      S_INIT, S_XFER: begin
        if (!cnt_last_s) begin
          cnt_nx = cnt_r - CNT_ONE;
        end else begin
          case (phase_r)
            PH_SETUP: begin
              phase_nx = PH_HIGH;
              cnt_nx   = LD_EH;
            end
            PH_HIGH: begin
              phase_nx = PH_HOLD;
              cnt_nx   = LD_HD;
            end
            PH_HOLD: begin
              // Low nibble follows the high nibble directly, without a wait in between.
              if (IS_4BIT && nib_hi_r && !single_r) begin
                nib_hi_nx = 1'b0;
                phase_nx  = PH_SETUP;
                cnt_nx    = LD_ST;
              end else begin
                state_nx = (state_r == S_INIT) ? S_INIT_WAIT : S_WAIT;
                cnt_nx   = wait_load(wsel_r);
              end
            end
            default: begin
              phase_nx = PH_SETUP;
              cnt_nx   = LD_ST;
            end
          endcase
        end
      end
      S_IDLE: begin
        if (accept_s) begin
          state_nx  = S_XFER;
          phase_nx  = PH_SETUP;
          cnt_nx    = LD_ST;
          nib_hi_nx = 1'b1;
          byte_nx   = cmd_data;
          rs_nx     = cmd_rs;
          single_nx = 1'b0;
          wsel_nx   = slow_cmd_s ? W_CLR : W_CMD;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_last_s) begin
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nx = S_POWERUP;
        cnt_nx   = LD_PU;
      end
    endcase

    strobe_nx_s  = (state_nx == S_INIT) || (state_nx == S_XFER);
    lcd_e_nx     = strobe_nx_s && (phase_nx == PH_HIGH);
    lcd_data_nx  = strobe_nx_s ? pin_byte(byte_nx, nib_hi_nx) : lcd_data_r;
    lcd_rs_nx    = strobe_nx_s ? rs_nx : lcd_rs_r;
    // Ready lags entry into IDLE by one cycle and drops on the accepting edge.
    cmd_ready_nx = (state_r == S_IDLE) && !accept_s;
  end

  // State, counter, latched transfer and registered output pins.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_r     <= S_POWERUP;
      phase_r     <= PH_SETUP;
      wsel_r      <= W_CMD;
      cnt_r       <= LD_PU;
      idx_r       <= 3'd0;
      nib_hi_r    <= 1'b1;
      byte_r      <= 8'h00;
      rs_r        <= 1'b0;
      single_r    <= 1'b0;
      init_done_r <= 1'b0;
      cmd_ready_r <= 1'b0;
      lcd_rs_r    <= 1'b0;
      lcd_e_r     <= 1'b0;
      lcd_data_r  <= 8'h00;
    end else begin
      state_r     <= state_nx;
      phase_r     <= phase_nx;
      wsel_r      <= wsel_nx;
      cnt_r       <= cnt_nx;
      idx_r       <= idx_nx;
      nib_hi_r    <= nib_hi_nx;
      byte_r      <= byte_nx;
      rs_r        <= rs_nx;
      single_r    <= single_nx;
      init_done_r <= init_done_nx;
      cmd_ready_r <= cmd_ready_nx;
      lcd_rs_r    <= lcd_rs_nx;
      lcd_e_r     <= lcd_e_nx;
      lcd_data_r  <= lcd_data_nx;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign init_done = init_done_r;
  assign lcd_rs    = lcd_rs_r;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = lcd_e_r;
  assign lcd_data  = lcd_data_r;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Scoreboard bench for lcd_hd44780_ctrl: an 8-bit and a 4-bit instance, expected
// {rw,rs,data} queued on stimulus and compared at every E falling edge.
module tb_lcd_hd44780_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       v8, rdy8, rs8, done8, lrs8, lrw8, le8;
  logic [7:0] d8, ld8;
  logic       v4, rdy4, rs4, done4, lrs4, lrw4, le4;
  logic [7:0] d4, ld4;

  lcd_hd44780_ctrl #(
    .BUS_WIDTH(8), .NUM_LINES(2), .POWERUP_CYC(50), .WAKE_WAIT_CYC(20), .SETUP_CYC(2),
    .E_HIGH_CYC(3), .HOLD_CYC(2), .CMD_WAIT_CYC(10), .CLEAR_WAIT_CYC(40)
  ) dut8 (
    .CLOCK_50(clk), .rst(rst), .cmd_valid(v8), .cmd_ready(rdy8), .cmd_rs(rs8),
    .cmd_data(d8), .init_done(done8), .lcd_rs(lrs8), .lcd_rw(lrw8), .lcd_e(le8),
    .lcd_data(ld8)
  );

  lcd_hd44780_ctrl #(
    .BUS_WIDTH(4), .NUM_LINES(2), .POWERUP_CYC(50), .WAKE_WAIT_CYC(20), .SETUP_CYC(2),
    .E_HIGH_CYC(3), .HOLD_CYC(2), .CMD_WAIT_CYC(10), .CLEAR_WAIT_CYC(40)
  ) dut4 (
    .CLOCK_50(clk), .rst(rst), .cmd_valid(v4), .cmd_ready(rdy4), .cmd_rs(rs4),
    .cmd_data(d4), .init_done(done4), .lcd_rs(lrs4), .lcd_rw(lrw4), .lcd_e(le4),
    .lcd_data(ld4)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [9:0] q8[$];
  logic [9:0] q4[$];
  logic [7:0] init8[7]  = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01, 8'h06};
  logic [7:0] init4[12] = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h20, 8'h80,
                            8'h00, 8'hC0, 8'h00, 8'h10, 8'h00, 8'h60};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // E-strobe monitors: data stable over the pulse, latched value matches the scoreboard.
  logic       e8_prev = 1'b0, e4_prev = 1'b0;
  logic [9:0] rise8, rise4;
  int         last_fall8 = 0, last_fall4 = 0;

  always @(negedge clk) begin
    if (!rst && le8 && !e8_prev) rise8 = {lrw8, lrs8, ld8};
    if (!rst && e8_prev && !le8) begin
      check("stable8", {lrw8, lrs8, ld8}, rise8);
      check("q8_has_entry", q8.size() != 0, 1);
      if (q8.size() != 0) check("strobe8", {lrw8, lrs8, ld8}, q8.pop_front());
      last_fall8 = cyc;
    end
    e8_prev = le8;
  end

  always @(negedge clk) begin
    if (!rst && le4 && !e4_prev) rise4 = {lrw4, lrs4, ld4};
    if (!rst && e4_prev && !le4) begin
      check("stable4", {lrw4, lrs4, ld4}, rise4);
      check("q4_has_entry", q4.size() != 0, 1);
      if (q4.size() != 0) check("strobe4", {lrw4, lrs4, ld4}, q4.pop_front());
      last_fall4 = cyc;
    end
    e4_prev = le4;
  end

  task automatic push_init();
    foreach (init8[i]) q8.push_back({2'b00, init8[i]});
    foreach (init4[i]) q4.push_back({2'b00, init4[i]});
  endtask

  task automatic wait_done(input bit four);
    int k = 0;
    while (!(four ? done4 : done8) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check(four ? "init4_timeout" : "init8_timeout", four ? done4 : done8, 1);
    check(four ? "init4_after_wait" : "init8_after_wait",
          cyc - (four ? last_fall4 : last_fall8), 12);
    check(four ? "rdy4_lags_done" : "rdy8_lags_done", four ? rdy4 : rdy8, 0);
    @(negedge clk);
    check(four ? "rdy4_after_init" : "rdy8_after_init", four ? rdy4 : rdy8, 1);
  endtask

  // Drive one byte at a negedge; keep=1 leaves cmd_valid high with junk while busy.
  task automatic send(input bit four, input logic rs, input logic [7:0] d,
                      input int exp_lat, input bit keep);
    int k   = 0;
    int lat = 0;
    while (!(four ? rdy4 : rdy8) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check(four ? "rdy4_timeout" : "rdy8_timeout", four ? rdy4 : rdy8, 1);
    if (four) begin
      v4 = 1'b1; rs4 = rs; d4 = d;
      q4.push_back({1'b0, rs, d[7:4], 4'h0});
      q4.push_back({1'b0, rs, d[3:0], 4'h0});
    end else begin
      v8 = 1'b1; rs8 = rs; d8 = d;
      q8.push_back({1'b0, rs, d});
    end
    @(posedge clk);
    @(negedge clk);
    if (four) begin
      if (keep) d4 = ~d; else v4 = 1'b0;
    end else begin
      if (keep) d8 = ~d; else v8 = 1'b0;
    end
    while (!(four ? rdy4 : rdy8) && lat < 500) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check(four ? "ready_latency4" : "ready_latency8", lat, exp_lat);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    v8 = 1'b0; rs8 = 1'b0; d8 = 8'h00;
    v4 = 1'b0; rs4 = 1'b0; d4 = 8'h00;
    repeat (3) @(negedge clk);
    check("reset8", {le8, lrs8, lrw8, rdy8, done8, ld8}, 0);
    check("reset4", {le4, lrs4, lrw4, rdy4, done4, ld4}, 0);

    push_init();
    rst = 1'b0;
    wait_done(1'b0);
    check("q8_init_drained", q8.size(), 0);
    wait_done(1'b1);
    check("q4_init_drained", q4.size(), 0);

    send(1'b0, 1'b1, 8'h41, 18, 1'b0);
    send(1'b0, 1'b0, 8'h01, 48, 1'b1);
    send(1'b0, 1'b0, 8'h80, 18, 1'b0);
    send(1'b0, 1'b1, 8'h48, 18, 1'b1);
    send(1'b0, 1'b1, 8'h49, 18, 1'b1);
    send(1'b0, 1'b1, 8'h21, 18, 1'b0);
    send(1'b0, 1'b0, 8'h02, 48, 1'b0);
    send(1'b0, 1'b0, 8'h03, 48, 1'b0);
    send(1'b1, 1'b1, 8'h41, 25, 1'b0);
    send(1'b1, 1'b0, 8'h01, 55, 1'b0);
    check("q8_drained", q8.size(), 0);
    check("q4_drained", q4.size(), 0);

    // Abort a data write while E is high.
    v8 = 1'b1; rs8 = 1'b1; d8 = 8'h55;
    @(posedge clk);
    @(negedge clk);
    v8 = 1'b0;
    k = 0;
    while (!le8 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("e_high_before_abort", le8, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort8", {le8, lrs8, lrw8, rdy8, done8, ld8}, 0);
    check("abort4", {le4, lrs4, lrw4, rdy4, done4, ld4}, 0);
    q8.delete();
    q4.delete();
    push_init();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("powerup_quiet8", {le8, done8, rdy8}, 0);
    wait_done(1'b0);
    check("q8_reinit_drained", q8.size(), 0);
    wait_done(1'b1);
    check("q4_reinit_drained", q4.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    check("global_timeout", 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "simulation time limit reached");
  end

endmodule
